// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single fixed-latency memory port.
// Each access occupies the mmu for MEM_LATENCY cycles, followed by a one-cycle response state.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    wait_if,
    input  logic [1:0]              op_mem,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    wait_mem,
    output logic [DATA_WIDTH/8-1:0] mmu_write_enable,
    output logic [ADDR_WIDTH-1:0]   mmu_address,
    output logic [DATA_WIDTH-1:0]   mmu_data_in,
    input  logic [DATA_WIDTH-1:0]   mmu_data_out
);

    localparam int unsigned     CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACC_IF,
        ACC_MEM,
        RESP_IF,
        RESP_MEM
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             mem_is_write;
    logic             mem_pend;
    logic             acc_last;
    logic             grant_if;
    logic             grant_mem;

    assign mem_pend = op_mem[1];
    assign acc_last = (cnt == '0);

    assign wait_if  = if_req   && (state != RESP_IF);
    assign wait_mem = mem_pend && (state != RESP_MEM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_mem  = 1'b0;
        case (state)
            IDLE, RESP_IF, RESP_MEM: begin
                // MEM has priority except straight after a MEM access, so fetch cannot starve
                if (mem_pend && !(if_req && state == RESP_MEM)) begin
                    grant_mem = 1'b1;
                end else if (if_req) begin
                    grant_if = 1'b1;
                end
                if (grant_mem) begin
                    state_next = ACC_MEM;
                end else if (grant_if) begin
                    state_next = ACC_IF;
                end else begin
                    state_next = IDLE;
                end
            end
            ACC_IF: begin
                if (acc_last) begin
                    state_next = RESP_IF;
                end
            end
            ACC_MEM: begin
                if (acc_last) begin
                    state_next = RESP_MEM;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt              <= '0;
            mem_is_write     <= 1'b0;
            mmu_write_enable <= '0;
            mmu_address      <= '0;
            mmu_data_in      <= '0;
            if_rdata         <= '0;
            mem_rdata        <= '0;
        end else begin
            mmu_write_enable <= '0;
            if (grant_mem) begin
                mmu_address  <= mem_addr;
                mmu_data_in  <= mem_wdata;
                cnt          <= CNT_LOAD;
                mem_is_write <= op_mem[0];
                if (op_mem[0]) begin
                    mmu_write_enable <= mem_be;
                end
            end else if (grant_if) begin
                mmu_address <= if_addr;
                mmu_data_in <= '0;
                cnt         <= CNT_LOAD;
            end else if ((state == ACC_IF || state == ACC_MEM) && !acc_last) begin
                cnt <= cnt - 1'b1;
            end

            if (state == ACC_IF && acc_last) begin
                if_rdata <= mmu_data_out;
            end
            if (state == ACC_MEM && acc_last && !mem_is_write) begin
                mem_rdata <= mmu_data_out;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed arbitration/reset sequences,
// then randomized traffic against a timestamp-based transaction model.
module tb_mem_port_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int BW         = DW / 8;
    localparam int LAT        = 4;
    localparam int RND_CYCLES = 300;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          wait_if;
    logic [1:0]    op_mem = 2'b00;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [BW-1:0] mem_be = '0;
    logic [DW-1:0] mem_rdata;
    logic          wait_mem;
    logic [BW-1:0] mmu_write_enable;
    logic [AW-1:0] mmu_address;
    logic [DW-1:0] mmu_data_in;
    logic [DW-1:0] mmu_data_out;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .if_rdata        (if_rdata),
        .wait_if         (wait_if),
        .op_mem          (op_mem),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_be          (mem_be),
        .mem_rdata       (mem_rdata),
        .wait_mem        (wait_mem),
        .mmu_write_enable(mmu_write_enable),
        .mmu_address     (mmu_address),
        .mmu_data_in     (mmu_data_in),
        .mmu_data_out    (mmu_data_out)
    );

    // Environment memory: 64 words indexed by the low address bits, byte writes on enable.
    logic [DW-1:0] mmu_mem [64];
    logic          mem_load = 1'b1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 10) return 32'd42;
        if (i == 20) return 32'h1122_3344;
        return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mmu_mem[i] <= init_word(i);
        end else begin
            for (int b = 0; b < BW; b++)
                if (mmu_write_enable[b]) mmu_mem[mmu_address[5:0]][8*b +: 8] <= mmu_data_in[8*b +: 8];
        end
    end
    assign mmu_data_out = mmu_mem[mmu_address[5:0]];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drain();
        @(posedge clk); #1;
        if_req = 1'b0;
        op_mem = 2'b00;
        repeat (LAT + 3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        is_if;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        int          exp_stall;
        int          exp_writes;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int          stall  = 0;
        int          writes = 0;
        bit          done   = 1'b0;
        logic [31:0] rd     = '0;
        logic        w;
        @(posedge clk); #1;
        if_req    = v.is_if;
        if_addr   = v.addr;
        op_mem    = v.is_if ? 2'b00 : v.op;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_be    = v.be;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            w = v.is_if ? wait_if : wait_mem;
            if (k <= LAT + 2 && mmu_write_enable != '0) writes++;
            if (!done) begin
                if (!w) begin
                    done = 1'b1;
                    rd   = v.is_if ? if_rdata : mem_rdata;
                end else begin
                    stall++;
                end
            end
            if (done && k >= LAT + 2) break;
        end
        check({tag, " stall"}, 32'(stall), 32'(v.exp_stall));
        check({tag, " writes"}, 32'(writes), 32'(v.exp_writes));
        if (v.is_if || v.op == 2'b10) check({tag, " rdata"}, rd, v.exp_rdata);
        drain();
    endtask

    // Both ports requesting from idle; records the cycles in which each stall drops.
    int          q_if[$];
    int          q_mem[$];
    int          max_if;
    int          max_mem;
    logic [31:0] rd_if_first;
    logic [31:0] rd_mem_first;

    function automatic int q_at(input int q[$], input int i);
        if (q.size() > i) return q[i];
        return -1;
    endfunction

    task automatic dual(input bit hold, input int ncyc);
        int s_if  = 0;
        int s_mem = 0;
        q_if.delete();
        q_mem.delete();
        max_if  = 0;
        max_mem = 0;
        @(posedge clk); #1;
        if_req   = 1'b1;
        if_addr  = 32'd10;
        op_mem   = 2'b10;
        mem_addr = 32'd20;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (if_req && !wait_if) begin
                if (q_if.size() == 0) rd_if_first = if_rdata;
                q_if.push_back(k);
            end
            if (op_mem[1] && !wait_mem) begin
                if (q_mem.size() == 0) rd_mem_first = mem_rdata;
                q_mem.push_back(k);
            end
            s_if  = wait_if  ? s_if + 1  : 0;
            s_mem = wait_mem ? s_mem + 1 : 0;
            if (s_if > max_if) max_if = s_if;
            if (s_mem > max_mem) max_mem = s_mem;
            @(posedge clk); #1;
            if (!hold) begin
                if (q_if.size() > 0) if_req = 1'b0;
                if (q_mem.size() > 0) op_mem = 2'b00;
            end
        end
        drain();
    endtask

    // Transaction model: each grant is stamped with its completion cycle; the port is free again
    // from that cycle on. Memory contents are tracked in a shadow array updated at grant time.
    logic [31:0] shadow [64];
    int          if_done, mem_done, next_free, we_cycle, if_block, mem_block;
    logic [3:0]  we_be;
    logic [31:0] if_val, mem_val, exp_if_rd, exp_mem_rd;
    bit          mem_wr;

    task automatic stim_if(input int c);
        int r;
        if (if_req) begin
            if (if_done >= c) begin
                r = int'($urandom_range(0, 99));
                if (r < 8) begin
                    if_req   = 1'b0;
                    if_block = if_done;
                end else if (r < 50 && if_done > c) begin
                    if_addr = 32'($urandom_range(0, 63));
                end
            end
        end else if (c > if_block && $urandom_range(0, 99) < 35) begin
            if_req  = 1'b1;
            if_addr = 32'($urandom_range(0, 63));
        end
    endtask

    task automatic new_mem_op();
        op_mem    = $urandom_range(0, 1) ? 2'b11 : 2'b10;
        mem_addr  = 32'($urandom_range(0, 63));
        mem_wdata = $urandom;
        mem_be    = 4'($urandom_range(0, 15));
    endtask

    task automatic stim_mem(input int c);
        int r;
        if (op_mem[1]) begin
            if (mem_done >= c) begin
                r = int'($urandom_range(0, 99));
                if (r < 8) begin
                    op_mem    = 2'b00;
                    mem_block = mem_done;
                end else if (r < 50 && mem_done > c) begin
                    new_mem_op();
                end
            end
        end else if (c > mem_block && $urandom_range(0, 99) < 35) begin
            new_mem_op();
        end else begin
            op_mem = $urandom_range(0, 1) ? 2'b01 : 2'b00;
        end
    endtask

    task automatic rnd_phase();
        logic [1:0] e_waits;
        logic [3:0] e_we;
        int         idx;
        rst_n  = 1'b0;
        if_req = 1'b0;
        op_mem = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) shadow[i] = mmu_mem[i];
        if_done    = -10;
        mem_done   = -10;
        next_free  = 0;
        we_cycle   = -10;
        we_be      = '0;
        if_block   = -1;
        mem_block  = -1;
        if_val     = '0;
        mem_val    = '0;
        exp_if_rd  = '0;
        exp_mem_rd = '0;
        mem_wr     = 1'b0;
        for (int c = 0; c < RND_CYCLES; c++) begin
            @(posedge clk); #1;
            stim_if(c);
            stim_mem(c);
            e_waits = {if_req && (if_done != c), op_mem[1] && (mem_done != c)};
            if (if_done == c) exp_if_rd = if_val;
            if (mem_done == c && !mem_wr) exp_mem_rd = mem_val;
            e_we = (we_cycle == c) ? we_be : 4'b0000;
            if (c >= next_free) begin
                if (op_mem[1] && !(if_req && mem_done == c)) begin
                    idx       = int'(mem_addr[5:0]);
                    mem_done  = c + LAT + 1;
                    next_free = mem_done;
                    mem_wr    = op_mem[0];
                    if (op_mem[0]) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b]) shadow[idx][8*b +: 8] = mem_wdata[8*b +: 8];
                        we_cycle = c + 1;
                        we_be    = mem_be;
                    end else begin
                        mem_val = shadow[idx];
                    end
                end else if (if_req) begin
                    if_done   = c + LAT + 1;
                    next_free = if_done;
                    if_val    = shadow[int'(if_addr[5:0])];
                end
            end
            @(negedge clk);
            check($sformatf("rnd c%0d waits", c), 32'({wait_if, wait_mem}), 32'(e_waits));
            check($sformatf("rnd c%0d if_rdata", c), if_rdata, exp_if_rd);
            check($sformatf("rnd c%0d mem_rdata", c), mem_rdata, exp_mem_rd);
            check($sformatf("rnd c%0d write_enable", c), 32'(mmu_write_enable), 32'(e_we));
        end
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        vec_t v;
        // {is_if, op, addr, wdata, be, exp_rdata, exp_stall, exp_writes}
        vecs[0] = '{1'b1, 2'b00, 32'd10, 32'h0,         4'b0000, 32'd42,        5, 0};
        vecs[1] = '{1'b0, 2'b11, 32'd20, 32'hAABB_CCDD, 4'b0011, 32'h0,         5, 1};
        vecs[2] = '{1'b0, 2'b10, 32'd20, 32'h0,         4'b0000, 32'h1122_CCDD, 5, 0};
        vecs[3] = '{1'b0, 2'b01, 32'd20, 32'hFFFF_FFFF, 4'b1111, 32'h0,         0, 0};
        vecs[4] = '{1'b1, 2'b00, 32'd20, 32'h0,         4'b0000, 32'h1122_CCDD, 5, 0};
        vecs[5] = '{1'b0, 2'b11, 32'd33, 32'hDEAD_BEEF, 4'b1111, 32'h0,         5, 1};
        vecs[6] = '{1'b1, 2'b00, 32'd33, 32'h0,         4'b0000, 32'hDEAD_BEEF, 5, 0};
        vecs[7] = '{1'b0, 2'b11, 32'd33, 32'h1100_0000, 4'b1000, 32'h0,         5, 1};
        vecs[8] = '{1'b0, 2'b10, 32'd33, 32'h0,         4'b0000, 32'h11AD_BEEF, 5, 0};

        // Reset with both requests pending: registers cleared, both requesters stalled.
        #3;
        if_req = 1'b1;
        op_mem = 2'b10;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset if_rdata", if_rdata, 32'h0);
        check("reset mem_rdata", mem_rdata, 32'h0);
        check("reset mmu_we", 32'(mmu_write_enable), 32'h0);
        check("reset mmu_address", mmu_address, 32'h0);
        check("reset mmu_data_in", mmu_data_in, 32'h0);
        check("reset waits", 32'({wait_if, wait_mem}), 32'h3);
        if_req   = 1'b0;
        op_mem   = 2'b00;
        mem_load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        dual(1'b0, 13);
        check("both: mem done cycle", 32'(q_at(q_mem, 0)), 32'd6);
        check("both: if done cycle", 32'(q_at(q_if, 0)), 32'd11);
        check("both: mem_rdata", rd_mem_first, 32'h1122_CCDD);
        check("both: if_rdata", rd_if_first, 32'd42);

        dual(1'b1, 17);
        check("held: grants mem", 32'(q_mem.size()), 32'd2);
        check("held: grants if", 32'(q_if.size()), 32'd1);
        check("held: 1st MEM", 32'(q_at(q_mem, 0)), 32'd6);
        check("held: 2nd IF", 32'(q_at(q_if, 0)), 32'd11);
        check("held: 3rd MEM", 32'(q_at(q_mem, 1)), 32'd16);
        check("held: if wait <= 10", 32'(max_if <= 10), 32'd1);
        check("held: mem wait <= 10", 32'(max_mem <= 10), 32'd1);

        // Reset two cycles into a store: the first-cycle write stands, mmu outputs clear at once.
        @(posedge clk); #1;
        op_mem    = 2'b11;
        mem_addr  = 32'd30;
        mem_wdata = 32'h600D_F00D;
        mem_be    = 4'b1111;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset mmu_we", 32'(mmu_write_enable), 32'h0);
        check("midreset mmu_address", mmu_address, 32'h0);
        check("midreset mmu_data_in", mmu_data_in, 32'h0);
        check("midreset wait_mem", 32'(wait_mem), 32'h1);
        op_mem = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{1'b1, 2'b00, 32'd30, 32'h0, 4'b0000, 32'h600D_F00D, 5, 0};
        run_vec(v, "postreset if30");
        v = '{1'b1, 2'b00, 32'd10, 32'h0, 4'b0000, 32'd42, 5, 0};
        run_vec(v, "postreset if10");

        rnd_phase();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
